// File: rtl/dm_mw_stage.sv
// M-stage data memory with byte/half/word lane stores and misalignment detection,
// plus the M/W latch carrying the raw read word and load-extension controls to W.
module dm_mw_stage #(
   parameter int DM_WORDS = 4096,
   parameter int IDX_W    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite_M,
   input  logic [31:0] Addr_M,
   input  logic [31:0] WD_M,
   input  logic [1:0]  BEOp_M,
   input  logic        LoadExtOp_M,
   input  logic        En_W,
   input  logic        Clr_W,
   output logic        AdErr_M,
   output logic [31:0] Dr_W,
   output logic [1:0]  Addr_W,
   output logic [1:0]  BEOp_W,
   output logic        LoadExtOp_W
);

   localparam logic [1:0] BE_WORD = 2'b00;
   localparam logic [1:0] BE_HALF = 2'b01;
   localparam logic [1:0] BE_BYTE = 2'b10;

   logic [31:0]      mem_q [DM_WORDS];
   logic [IDX_W-1:0] idx;
   logic             misal;
   logic             oor;
   logic             we;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      rd_m;

   logic [31:0] dr_q, dr_d;
   logic [1:0]  addr_q, addr_d;
   logic [1:0]  beop_q, beop_d;
   logic        ext_q, ext_d;

   assign idx = Addr_M[IDX_W+1:2];

   always_comb begin
      misal   = ((BEOp_M == BE_HALF) && Addr_M[0])
             || ((BEOp_M == BE_WORD) && (Addr_M[1:0] != 2'b00));
      oor     = |Addr_M[31:IDX_W+2];
      AdErr_M = misal | oor;
      rd_m    = AdErr_M ? 32'h0 : mem_q[idx];
   end

   // Store data is replicated across lanes so each enable picks its own byte.
   always_comb begin
      be    = 4'b0000;
      wdata = WD_M;
      case (BEOp_M)
         BE_BYTE: begin
            be[Addr_M[1:0]] = 1'b1;
            wdata = {4{WD_M[7:0]}};
         end
         BE_HALF: begin
            be    = Addr_M[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WD_M[15:0]}};
         end
         BE_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      we = MemWrite_M & ~AdErr_M;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'h0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (we && be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_comb begin
      dr_d   = dr_q;
      addr_d = addr_q;
      beop_d = beop_q;
      ext_d  = ext_q;
      if (Clr_W) begin
         dr_d   = 32'h0;
         addr_d = 2'b00;
         beop_d = 2'b00;
         ext_d  = 1'b0;
      end else if (En_W) begin
         dr_d   = rd_m;
         addr_d = Addr_M[1:0];
         beop_d = BEOp_M;
         ext_d  = LoadExtOp_M;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dr_q   <= 32'h0;
         addr_q <= 2'b00;
         beop_q <= 2'b00;
         ext_q  <= 1'b0;
      end else begin
         dr_q   <= dr_d;
         addr_q <= addr_d;
         beop_q <= beop_d;
         ext_q  <= ext_d;
      end
   end

   assign Dr_W        = dr_q;
   assign Addr_W      = addr_q;
   assign BEOp_W      = beop_q;
   assign LoadExtOp_W = ext_q;

endmodule
